// File: rtl/ct_lsu_dcache_tag_req_ctrl.sv
// LSU dcache load-tag SRAM requester: single read/write access
// arbitration against a full invalidate sweep, with one-cycle read return.
module ct_lsu_dcache_tag_req_ctrl #(
    parameter int SETS          = 512,
    parameter int IDX_W         = 9,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst,
    input  logic             req_vld,
    output logic             req_rdy,
    input  logic             req_wr,
    input  logic [1:0]       req_way_mask,
    input  logic [IDX_W-1:0] req_idx,
    input  logic [26:0]      req_tag,
    input  logic             inv_start,
    output logic             inv_busy,
    output logic             inv_done,
    output logic             rsp_vld,
    output logic [26:0]      rsp_tag_way0,
    output logic [26:0]      rsp_tag_way1,
    output logic             tag_gateclk_en,
    output logic             tag_sel_b,
    output logic             tag_gwen_b,
    output logic [1:0]       tag_wen_b,
    output logic [IDX_W-1:0] tag_idx,
    output logic [53:0]      tag_din,
    input  logic [53:0]      tag_dout
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LP_LAST     = IDX_W'(SETS - 1);
    localparam logic [IDX_W-1:0] LP_IDX_MASK = IDX_W'(SETS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_cnt;
    logic [IDX_W-1:0] w_cnt_nxt;
    logic             r_init_done;
    logic             w_init_done_nxt;
    logic             r_rsp_vld;
    logic             w_rsp_vld_nxt;
    logic             r_inv_done;
    logic             w_inv_done_nxt;

    logic             w_init_pend;
    logic             w_req_rdy;
    logic             w_inv_busy;
    logic             w_sel_b;
    logic             w_gwen_b;
    logic [1:0]       w_wen_b;
    logic [IDX_W-1:0] w_idx;
    logic [53:0]      w_din;

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_rsp_vld   <= 1'b0;
            r_inv_done  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_init_done <= w_init_done_nxt;
            r_rsp_vld   <= w_rsp_vld_nxt;
            r_inv_done  <= w_inv_done_nxt;
        end
    end

    // The first cycle out of reset turns into a sweep when init is enabled
    assign w_init_pend = INIT_ON_RESET && !r_init_done;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_init_done_nxt = r_init_done;
        w_rsp_vld_nxt   = 1'b0;
        w_inv_done_nxt  = 1'b0;
        w_req_rdy       = 1'b0;
        w_inv_busy      = 1'b0;
        w_sel_b         = 1'b1;
        w_gwen_b        = 1'b1;
        w_wen_b         = 2'b11;
        w_idx           = '0;
        w_din           = '0;

        unique case (r_state)
            ST_IDLE: begin
                w_init_done_nxt = 1'b1;
                if (inv_start || w_init_pend) begin
                    w_state_nxt = ST_SWEEP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_req_rdy = 1'b1;
                    if (req_vld && !req_wr) begin
                        w_sel_b       = 1'b0;
                        w_idx         = req_idx & LP_IDX_MASK;
                        w_rsp_vld_nxt = 1'b1;
                    end else if (req_vld && (|req_way_mask)) begin
                        w_sel_b  = 1'b0;
                        w_gwen_b = 1'b0;
                        w_wen_b  = ~req_way_mask;
                        w_idx    = req_idx & LP_IDX_MASK;
                        w_din    = {req_tag, req_tag};
                    end
                end
            end
            ST_SWEEP: begin
                w_inv_busy = 1'b1;
                w_sel_b    = 1'b0;
                w_gwen_b   = 1'b0;
                w_wen_b    = 2'b00;
                w_idx      = r_cnt;
                if (r_cnt == LP_LAST) begin
                    w_state_nxt    = ST_IDLE;
                    w_cnt_nxt      = '0;
                    w_inv_done_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // Reset aborts any access in the same cycle
        if (cpurst) begin
            w_req_rdy  = 1'b0;
            w_inv_busy = 1'b0;
            w_sel_b    = 1'b1;
            w_gwen_b   = 1'b1;
            w_wen_b    = 2'b11;
            w_idx      = '0;
            w_din      = '0;
        end
    end

    assign req_rdy        = w_req_rdy;
    assign inv_busy       = w_inv_busy;
    assign inv_done       = r_inv_done & ~cpurst;
    assign rsp_vld        = r_rsp_vld & ~cpurst;
    assign rsp_tag_way0   = tag_dout[26:0];
    assign rsp_tag_way1   = tag_dout[53:27];
    assign tag_sel_b      = w_sel_b;
    assign tag_gateclk_en = ~w_sel_b;
    assign tag_gwen_b     = w_gwen_b;
    assign tag_wen_b      = w_wen_b;
    assign tag_idx        = w_idx;
    assign tag_din        = w_din;

endmodule

// File: tb/tb_ct_lsu_dcache_tag_req_ctrl.sv
// Self-checking bench for ct_lsu_dcache_tag_req_ctrl: SRAM model plus
// reference tag store, randomized accesses and sweep/reset scenarios.
module tb_ct_lsu_dcache_tag_req_ctrl;

    logic        clk = 1'b0;
    logic        cpurst;
    logic        req_vld;
    logic        req_rdy;
    logic        req_wr;
    logic [1:0]  req_way_mask;
    logic [8:0]  req_idx;
    logic [26:0] req_tag;
    logic        inv_start;
    logic        inv_busy;
    logic        inv_done;
    logic        rsp_vld;
    logic [26:0] rsp_tag_way0;
    logic [26:0] rsp_tag_way1;
    logic        tag_gateclk_en;
    logic        tag_sel_b;
    logic        tag_gwen_b;
    logic [1:0]  tag_wen_b;
    logic [8:0]  tag_idx;
    logic [53:0] tag_din;
    logic [53:0] tag_dout;

    int n_pass  = 0;
    int n_total = 0;

    logic [26:0] ref_w0 [0:511];
    logic [26:0] ref_w1 [0:511];
    logic [53:0] mem    [0:511];
    bit          seeded = 1'b0;

    localparam logic [13:0] IDLE_PINS = {1'b1, 1'b1, 2'b11, 9'd0, 1'b0};

    wire [13:0] pins = {tag_sel_b, tag_gwen_b, tag_wen_b, tag_idx, tag_gateclk_en};
    wire [3:0]  st   = {req_rdy, inv_busy, inv_done, rsp_vld};
    wire [53:0] rsp  = {rsp_tag_way1, rsp_tag_way0};

    always #5 clk = ~clk;

    ct_lsu_dcache_tag_req_ctrl dut (
        .forever_cpuclk (clk),
        .cpurst         (cpurst),
        .req_vld        (req_vld),
        .req_rdy        (req_rdy),
        .req_wr         (req_wr),
        .req_way_mask   (req_way_mask),
        .req_idx        (req_idx),
        .req_tag        (req_tag),
        .inv_start      (inv_start),
        .inv_busy       (inv_busy),
        .inv_done       (inv_done),
        .rsp_vld        (rsp_vld),
        .rsp_tag_way0   (rsp_tag_way0),
        .rsp_tag_way1   (rsp_tag_way1),
        .tag_gateclk_en (tag_gateclk_en),
        .tag_sel_b      (tag_sel_b),
        .tag_gwen_b     (tag_gwen_b),
        .tag_wen_b      (tag_wen_b),
        .tag_idx        (tag_idx),
        .tag_din        (tag_din),
        .tag_dout       (tag_dout)
    );

    // Behavioural tag SRAM, starts with garbage so the sweep matters
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 512; i++)
                mem[i] <= 54'({$urandom(), $urandom()});
            seeded <= 1'b1;
        end else if (!tag_sel_b) begin
            if (!tag_gwen_b) begin
                if (!tag_wen_b[0]) mem[tag_idx][26:0]  <= tag_din[26:0];
                if (!tag_wen_b[1]) mem[tag_idx][53:27] <= tag_din[53:27];
            end else begin
                tag_dout <= mem[tag_idx];
            end
        end
    end

    function automatic logic [13:0] pins_for(input int kind,
                                             input logic [8:0] idx,
                                             input logic [1:0] mask);
        logic [13:0] r;
        case (kind)
            1: r = {1'b0, 1'b1, 2'b11, idx, 1'b1};
            2: r = (mask == 2'b00) ? IDLE_PINS : {1'b0, 1'b0, ~mask, idx, 1'b1};
            3: r = {1'b0, 1'b0, 2'b00, idx, 1'b1};
            default: r = IDLE_PINS;
        endcase
        return r;
    endfunction

    function automatic void ref_write(input logic [8:0] idx,
                                      input logic [1:0] mask,
                                      input logic [26:0] tag);
        if (mask[0]) ref_w0[idx] = tag;
        if (mask[1]) ref_w1[idx] = tag;
    endfunction

    task automatic drive(input logic v, input logic w, input logic [1:0] m,
                         input logic [8:0] i, input logic [26:0] t,
                         input logic inv);
        @(negedge clk);
        req_vld      = v;
        req_wr       = w;
        req_way_mask = m;
        req_idx      = i;
        req_tag      = t;
        inv_start    = inv;
        #1;
    endtask

    // Follows a full sweep that starts in the next driven cycle
    task automatic run_sweep(input int poke);
        for (int i = 0; i < 512; i++) begin
            drive(1'($urandom), 1'b0, 2'b11, 9'($urandom), 27'($urandom),
                  i == poke);
            n_total++;
            if (pins !== pins_for(3, 9'(i), 2'b00) || tag_din !== 54'd0 ||
                st !== 4'b0100) begin
                $display("FAIL sweep[%0d]: pins=%h din=%h st=%b exp pins=%h din=0 st=0100",
                         i, pins, tag_din, st, pins_for(3, 9'(i), 2'b00));
            end else n_pass++;
        end
        drive(1'b0, 1'b0, 2'b00, 9'd0, 27'd0, 1'b0);
        n_total++;
        if (pins !== IDLE_PINS || st !== 4'b1010)
            $display("FAIL sweep_done: pins=%h st=%b exp pins=%h st=1010",
                     pins, st, IDLE_PINS);
        else n_pass++;
        drive(1'b0, 1'b0, 2'b00, 9'd0, 27'd0, 1'b0);
        n_total++;
        if (st !== 4'b1000)
            $display("FAIL sweep_done_once: st=%b exp 1000", st);
        else n_pass++;
        for (int i = 0; i < 512; i++) begin
            ref_w0[i] = '0;
            ref_w1[i] = '0;
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        cpurst  = 1'b0;
        req_vld = 1'b0;
        #1;
        n_total++;
        if (pins !== IDLE_PINS || inv_busy !== 1'b0)
            $display("FAIL release_idle: pins=%h busy=%b exp pins=%h busy=0",
                     pins, inv_busy, IDLE_PINS);
        else n_pass++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'($urandom), 2'b11, 9'($urandom), 27'($urandom),
                  1'(i == 1));
            n_total++;
            if (pins !== IDLE_PINS || tag_din !== 54'd0 || st !== 4'b0000)
                $display("FAIL reset[%0d]: pins=%h din=%h st=%b exp pins=%h din=0 st=0000",
                         i, pins, tag_din, st, IDLE_PINS);
            else n_pass++;
        end
    endtask

    task automatic test_init_sweep();
        release_reset();
        run_sweep(-1);
    endtask

    task automatic test_write_read();
        drive(1'b1, 1'b1, 2'b10, 9'd5, 27'h1234567, 1'b0);
        n_total++;
        if (tag_wen_b !== 2'b01 || pins !== pins_for(2, 9'd5, 2'b10) ||
            tag_din !== {27'h1234567, 27'h1234567} || req_rdy !== 1'b1)
            $display("FAIL wr_pins: pins=%h din=%h rdy=%b exp pins=%h",
                     pins, tag_din, req_rdy, pins_for(2, 9'd5, 2'b10));
        else n_pass++;
        ref_write(9'd5, 2'b10, 27'h1234567);
        drive(1'b1, 1'b0, 2'b00, 9'd5, 27'd0, 1'b0);
        n_total++;
        if (pins !== pins_for(1, 9'd5, 2'b00) || rsp_vld !== 1'b0)
            $display("FAIL rd_pins: pins=%h rsp_vld=%b exp pins=%h rsp_vld=0",
                     pins, rsp_vld, pins_for(1, 9'd5, 2'b00));
        else n_pass++;
        drive(1'b0, 1'b0, 2'b00, 9'd0, 27'd0, 1'b0);
        n_total++;
        if (rsp_vld !== 1'b1 || rsp_tag_way1 !== 27'h1234567 ||
            rsp_tag_way0 !== 27'd0)
            $display("FAIL rd_rsp: vld=%b w1=%h w0=%h exp vld=1 w1=1234567 w0=0",
                     rsp_vld, rsp_tag_way1, rsp_tag_way0);
        else n_pass++;
    endtask

    task automatic test_mask_zero();
        drive(1'b1, 1'b1, 2'b00, 9'd5, 27'($urandom), 1'b0);
        n_total++;
        if (req_rdy !== 1'b1 || tag_sel_b !== 1'b1 || tag_gateclk_en !== 1'b0)
            $display("FAIL mask0_pins: rdy=%b sel_b=%b gate=%b exp rdy=1 sel_b=1 gate=0",
                     req_rdy, tag_sel_b, tag_gateclk_en);
        else n_pass++;
        drive(1'b1, 1'b0, 2'b00, 9'd5, 27'd0, 1'b0);
        drive(1'b0, 1'b0, 2'b00, 9'd0, 27'd0, 1'b0);
        n_total++;
        if (rsp_vld !== 1'b1 || rsp !== {ref_w1[5], ref_w0[5]})
            $display("FAIL mask0_keep: vld=%b data=%h exp vld=1 data=%h",
                     rsp_vld, rsp, {ref_w1[5], ref_w0[5]});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [26:0] t;
        for (int i = 1; i <= 4; i++) begin
            t = 27'($urandom);
            drive(1'b1, 1'b1, 2'b11, 9'(i), t, 1'b0);
            ref_write(9'(i), 2'b11, t);
        end
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) drive(1'b1, 1'b0, 2'b00, 9'(i), 27'd0, 1'b0);
            else drive(1'b0, 1'b0, 2'b00, 9'd0, 27'd0, 1'b0);
            n_total++;
            if (i == 1) begin
                if (rsp_vld !== 1'b0)
                    $display("FAIL b2b_rsp[0]: vld=%b exp 0", rsp_vld);
                else n_pass++;
            end else if (rsp_vld !== 1'b1 ||
                         rsp !== {ref_w1[i-1], ref_w0[i-1]}) begin
                $display("FAIL b2b_rsp[%0d]: vld=%b data=%h exp vld=1 data=%h",
                         i - 1, rsp_vld, rsp, {ref_w1[i-1], ref_w0[i-1]});
            end else n_pass++;
        end
    endtask

    task automatic test_random();
        logic        pend = 1'b0;
        logic [53:0] pend_data = '0;
        int          op;
        logic [8:0]  idx;
        logic [1:0]  mask;
        logic [26:0] tag;
        for (int n = 0; n < 300; n++) begin
            op   = int'($urandom_range(0, 3));
            idx  = 9'($urandom);
            mask = 2'($urandom);
            tag  = 27'($urandom);
            drive(1'(op != 0), 1'(op >= 2), mask, idx, tag, 1'b0);
            n_total++;
            if (req_rdy !== 1'b1 || pins !== pins_for(op >= 2 ? 2 : op, idx, mask) ||
                (op >= 2 && mask != 2'b00 && tag_din !== {tag, tag}))
                $display("FAIL rand_pins[%0d]: rdy=%b pins=%h din=%h exp pins=%h",
                         n, req_rdy, pins, tag_din,
                         pins_for(op >= 2 ? 2 : op, idx, mask));
            else n_pass++;
            n_total++;
            if (rsp_vld !== pend || (pend && rsp !== pend_data))
                $display("FAIL rand_rsp[%0d]: vld=%b data=%h exp vld=%b data=%h",
                         n, rsp_vld, rsp, pend, pend_data);
            else n_pass++;
            pend = (op == 1);
            if (op == 1) pend_data = {ref_w1[idx], ref_w0[idx]};
            if (op >= 2) ref_write(idx, mask, tag);
        end
        drive(1'b0, 1'b0, 2'b00, 9'd0, 27'd0, 1'b0);
        n_total++;
        if (rsp_vld !== pend || (pend && rsp !== pend_data))
            $display("FAIL rand_rsp_last: vld=%b data=%h exp vld=%b data=%h",
                     rsp_vld, rsp, pend, pend_data);
        else n_pass++;
    endtask

    task automatic test_collision();
        drive(1'b1, 1'b0, 2'b00, 9'd9, 27'd0, 1'b1);
        n_total++;
        if (req_rdy !== 1'b0 || pins !== IDLE_PINS)
            $display("FAIL collide: rdy=%b pins=%h exp rdy=0 pins=%h",
                     req_rdy, pins, IDLE_PINS);
        else n_pass++;
        run_sweep(10);
    endtask

    task automatic test_reset_mid_sweep();
        drive(1'b0, 1'b0, 2'b00, 9'd0, 27'd0, 1'b1);
        for (int i = 0; i < 100; i++)
            drive(1'b0, 1'b0, 2'b00, 9'd0, 27'd0, 1'b0);
        n_total++;
        if (pins !== pins_for(3, 9'd99, 2'b00))
            $display("FAIL mid_sweep_pos: pins=%h exp %h",
                     pins, pins_for(3, 9'd99, 2'b00));
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            cpurst = 1'b1;
            #1;
            n_total++;
            if (pins !== IDLE_PINS || st !== 4'b0000)
                $display("FAIL mid_sweep_rst[%0d]: pins=%h st=%b exp pins=%h st=0000",
                         i, pins, st, IDLE_PINS);
            else n_pass++;
        end
        release_reset();
        run_sweep(-1);
    endtask

    task automatic test_reset_drop();
        drive(1'b1, 1'b1, 2'b11, 9'd7, 27'($urandom), 1'b0);
        drive(1'b1, 1'b0, 2'b00, 9'd7, 27'd0, 1'b0);
        @(negedge clk);
        cpurst  = 1'b1;
        req_vld = 1'b0;
        #1;
        n_total++;
        if (rsp_vld !== 1'b0)
            $display("FAIL rst_drop: rsp_vld=%b exp 0", rsp_vld);
        else n_pass++;
        release_reset();
        run_sweep(-1);
    endtask

    initial begin
        cpurst       = 1'b1;
        req_vld      = 1'b0;
        req_wr       = 1'b0;
        req_way_mask = 2'b00;
        req_idx      = 9'd0;
        req_tag      = 27'd0;
        inv_start    = 1'b0;
        test_reset();
        test_init_sweep();
        test_write_read();
        test_mask_zero();
        test_back_to_back();
        test_random();
        test_collision();
        test_reset_mid_sweep();
        test_reset_drop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
